// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: hundredths stopwatch (SS.hh) with run/stop, lap freeze and clear buttons
module stopwatch_bcd #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [15:0] digits,
    output logic [3:0]  digit_en,
    output logic [3:0]  dp,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

    state_t          state, state_next;
    logic [2:0]      sync1, sync2, prev, evt;
    logic            clear_evt, ss_evt, lap_evt;
    logic [PW-1:0]   presc;
    logic [15:0]     count, count_inc, freeze;
    logic            counting, tick, wrap, freeze_load, zero;

    // bit 2 = clear, bit 1 = start_stop, bit 0 = lap
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {clear, start_stop, lap};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign evt       = sync2 & ~prev;
    assign clear_evt = evt[2];
    assign ss_evt    = evt[1];
    assign lap_evt   = evt[0];

    assign counting = (state == RUN) || (state == LAP);
    assign tick     = counting && (presc == PW'(TICK_DIV - 1));

    // BCD increment; wrap is the carry out of the tens digit
    always_comb begin
        count_inc = count;
        wrap      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (wrap) begin
                if (count[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    wrap                = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        freeze_load = 1'b0;
        zero        = 1'b0;
        case (state)
            IDLE: if (ss_evt) state_next = RUN;
            RUN: begin
                if (ss_evt) begin
                    state_next = STOP;
                end else if (lap_evt) begin
                    state_next  = LAP;
                    freeze_load = 1'b1;
                end
            end
            LAP: begin
                if (ss_evt)       state_next = STOP;
                else if (lap_evt) state_next = RUN;
            end
            STOP: begin
                if (clear_evt) begin
                    state_next = IDLE;
                    zero       = 1'b1;
                end else if (ss_evt) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // prescaler is held while stopped so a resumed run finishes the partial tick
    always_ff @(posedge clk) begin
        if (reset || zero) begin
            presc    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            freeze   <= '0;
        end else begin
            if (counting) presc <= tick ? '0 : presc + 1'b1;
            if (tick) count <= count_inc;
            if (tick && wrap) overflow <= 1'b1;
            if (freeze_load) freeze <= tick ? count_inc : count;
        end
    end

    assign digits     = (state == LAP) ? freeze : count;
    assign digit_en   = {digits[15:12] != 4'd0, 3'b111};
    assign dp         = 4'b0100;
    assign running    = counting;
    assign lap_active = (state == LAP);
endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Hundredths-resolution stopwatch that produces four BCD digits (SS.hh, 00.00–99.99) plus digit-enable and decimal-point vectors, driving the seven-segment controller stage directly. Sits upstream of the display controller in place of the free-running timer. Start/stop, lap-freeze and clear are taken from debounced button levels, synchronized and edge-detected internally.

## Interface
- `TICK_DIV`, 1_000_000: clk cycles per hundredth-second tick (100 MHz clock); benches use 4.
- `clk` in 1: system clock; one clock, all state on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start_stop` in 1: debounced button level; a rising edge toggles run/stop.
- `lap` in 1: debounced level; a rising edge toggles display freeze while running.
- `clear` in 1: debounced level; a rising edge zeroes the stopwatch when stopped.
- `digits` out 16: BCD; [15:12] tens of s, [11:8] s, [7:4] tenths, [3:0] hundredths.
- `digit_en` out 4: per-digit enable; bit 3 = (tens != 0), bits 2:0 = 1 (leading-zero blank).
- `dp` out 4: constant 4'b0100 (point after seconds digit).
- `running` out 1: high in RUN or LAP.
- `lap_active` out 1: high in LAP.
- `overflow` out 1: sticky; set on wrap 99.99 → 00.00.

## Operation
- Each button input: 2-flop synchronizer, then edge flop; event = sync & ~prev (one-cycle pulse).
- Prescaler 0..TICK_DIV-1 advances only in RUN/LAP; tick when it equals TICK_DIV-1 (prescaler → 0). Held (not cleared) in STOP, so a resumed run continues the partial tick.
- Tick increments 4-digit BCD count with carry chain (9 → 0 carries up); 99.99 + tick → 00.00 and overflow ← 1 on the same edge.
- FSM:
  - IDLE: count 0. start_stop → RUN. lap, clear ignored.
  - RUN: counting; digits = live count. start_stop → STOP; else lap → LAP (freeze register ← count value after that edge). clear ignored.
  - LAP: counting continues; digits = frozen value. start_stop → STOP (digits live); else lap → RUN (digits live).
  - STOP: no counting; digits = live count. clear → IDLE (count, prescaler, overflow → 0); else start_stop → RUN. lap ignored.
- Priority on simultaneous events: clear > start_stop > lap, per state above.
- digit_en/running/lap_active are decoded from registered state/digits; no combinational path from inputs to outputs.

## Timing
- Reset values: state IDLE, digits 16'h0000, digit_en 4'b0111, dp 4'b0100, running 0, lap_active 0, overflow 0, prescaler 0, all sync/edge flops 0.
- Input latency: input first sampled high at edge k → event high after edge k+1 → state/outputs change at edge k+2.
- Count latency: digits update on the same edge as the count register (registered output, zero extra cycles).
- In RUN from edge S (entry), first tick edge is S+TICK_DIV; subsequent ticks every TICK_DIV cycles.
- A tick coinciding with a stop event is counted (stop takes effect after that edge); a tick coinciding with a lap-freeze is captured in the frozen value.
- Held button: only one event per rising edge; level held high produces nothing further.
- Reset mid-operation overrides everything at the next edge, including pending events in sync flops.

## Test plan
- Reset, hold inputs low 20 cycles -> digits 16'h0000, digit_en 4'b0111, dp 4'b0100, running/lap_active/overflow 0 throughout.
- TICK_DIV=4, pulse start_stop -> running=1 two edges later; 160 cycles after entry digits=16'h0040; after 1000 ticks digits=16'h1000, digit_en=4'b1111.
- Run 10000 ticks -> digits 16'h0000, overflow=1, digit_en=4'b0111, counting continues (next tick 16'h0001).
- Lap at count 00.12 -> digits hold 16'h0012 while running stays 1; lap again 20 ticks later -> digits show live 16'h0032 (±0, cycle-exact from event edge).
- Clear during RUN -> ignored; stop, then start_stop and clear rising same cycle -> IDLE, digits 0, overflow 0, running 0.
- Assert reset mid-run at count 05.37 with lap pending in synchronizer -> all reset values next edge, no LAP entry afterwards.
